// File: rtl/axis_pack.sv
`default_nettype none
// ============================================================================
// Module      : axis_pack
// Description : Packs RATIO narrow AXI-Stream beats into one wide output word;
//               TLAST on the input flushes a partially filled word early.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_pack #(
  parameter int DIN_WIDTH  = 32,
  parameter int DOUT_WIDTH = 256,
  localparam int RATIO     = DOUT_WIDTH / DIN_WIDTH,
  localparam int LANE_W    = $clog2(RATIO) + 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DIN_WIDTH-1:0]  AXIS_RX_TDATA,
  input  logic                  AXIS_RX_TVALID,
  input  logic                  AXIS_RX_TLAST,
  output logic                  AXIS_RX_TREADY,
  output logic [DOUT_WIDTH-1:0] AXIS_TX_TDATA,
  output logic                  AXIS_TX_TVALID,
  output logic                  AXIS_TX_TLAST,
  output logic [LANE_W-1:0]     AXIS_TX_LANES,
  input  logic                  AXIS_TX_TREADY
);

  localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(RATIO - 1);

  generate
    if (((DOUT_WIDTH % DIN_WIDTH) != 0) || (RATIO < 2)) begin : g_bad_ratio
      $error("axis_pack: DOUT_WIDTH must be an integer multiple of DIN_WIDTH with RATIO >= 2");
    end
  endgenerate

  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DOUT_WIDTH-1:0] acc_q, acc_d;
  logic [DOUT_WIDTH-1:0] tx_data_q, tx_data_d;
  logic [LANE_W-1:0]     tx_lanes_q, tx_lanes_d;
  logic                  tx_last_q, tx_last_d;
  logic                  tx_valid_q, tx_valid_d;

  logic                  w_rx_ready;
  logic                  w_rx_fire;
  logic                  w_tx_fire;
  logic                  w_complete;
  logic [DOUT_WIDTH-1:0] w_merged;

  // Ready depends only on output-register state, never on RX_TVALID.
  assign w_rx_ready = !reset && (!tx_valid_q || AXIS_TX_TREADY);
  assign w_rx_fire  = AXIS_RX_TVALID && w_rx_ready;
  assign w_tx_fire  = tx_valid_q && AXIS_TX_TREADY;
  assign w_complete = (idx_q == c_last_idx) || AXIS_RX_TLAST;

  // Accumulator with the incoming beat dropped into lane idx and every lane
  // above it cleared, so a TLAST flush leaves the upper lanes zero-padded.
  always_comb begin
    w_merged = acc_q;
    for (int k = 0; k < RATIO; k++) begin
      if (k == int'(idx_q)) begin
        w_merged[k*DIN_WIDTH +: DIN_WIDTH] = AXIS_RX_TDATA;
      end else if (k > int'(idx_q)) begin
        w_merged[k*DIN_WIDTH +: DIN_WIDTH] = '0;
      end
    end
  end

  always_comb begin
    idx_d      = idx_q;
    acc_d      = acc_q;
    tx_data_d  = tx_data_q;
    tx_lanes_d = tx_lanes_q;
    tx_last_d  = tx_last_q;
    tx_valid_d = tx_valid_q;

    if (w_tx_fire) begin
      tx_valid_d = 1'b0;
    end

    if (w_rx_fire) begin
      if (w_complete) begin
        tx_data_d  = w_merged;
        tx_lanes_d = LANE_W'(idx_q) + LANE_W'(1);
        tx_last_d  = AXIS_RX_TLAST;
        tx_valid_d = 1'b1;
        acc_d      = '0;
        idx_d      = '0;
      end else begin
        acc_d      = w_merged;
        idx_d      = idx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q      <= '0;
      acc_q      <= '0;
      tx_data_q  <= '0;
      tx_lanes_q <= '0;
      tx_last_q  <= 1'b0;
      tx_valid_q <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      acc_q      <= acc_d;
      tx_data_q  <= tx_data_d;
      tx_lanes_q <= tx_lanes_d;
      tx_last_q  <= tx_last_d;
      tx_valid_q <= tx_valid_d;
    end
  end

  assign AXIS_RX_TREADY = w_rx_ready;
  assign AXIS_TX_TDATA  = tx_data_q;
  assign AXIS_TX_TVALID = tx_valid_q;
  assign AXIS_TX_TLAST  = tx_last_q;
  assign AXIS_TX_LANES  = tx_lanes_q;

endmodule
`default_nettype wire

// File: tb/tb_axis_pack.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_pack
// Description : Self-checking bench for axis_pack (8-bit in, 32-bit out).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_pack;

  localparam int DIN_W  = 8;
  localparam int DOUT_W = 32;

  logic              clk = 1'b0;
  logic              reset;
  logic [DIN_W-1:0]  rx_data;
  logic              rx_valid;
  logic              rx_last;
  logic              rx_ready;
  logic [DOUT_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_last;
  logic [2:0]        tx_lanes;
  logic              tx_ready;

  axis_pack #(
    .DIN_WIDTH  (DIN_W),
    .DOUT_WIDTH (DOUT_W)
  ) u_dut (
    .clk            (clk),
    .reset          (reset),
    .AXIS_RX_TDATA  (rx_data),
    .AXIS_RX_TVALID (rx_valid),
    .AXIS_RX_TLAST  (rx_last),
    .AXIS_RX_TREADY (rx_ready),
    .AXIS_TX_TDATA  (tx_data),
    .AXIS_TX_TVALID (tx_valid),
    .AXIS_TX_TLAST  (tx_last),
    .AXIS_TX_LANES  (tx_lanes),
    .AXIS_TX_TREADY (tx_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          lanes;
    bit          last;
  } word_t;

  word_t       exp_q[$];
  logic [7:0]  part_q[$];
  word_t       w_got;
  int          n_cmp = 0;
  int          n_err = 0;
  int          n_words = 0;
  int          cyc = 0;
  int          stall_cnt = 0;

  logic        hold_prev = 1'b0;
  logic [31:0] prev_data;
  logic [2:0]  prev_lanes;
  logic        prev_last;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: collect beats; a word is due once 4 beats are held or TLAST arrives.
  task automatic model_beat(input logic [7:0] d, input bit last);
    word_t w;
    part_q.push_back(d);
    if (part_q.size() == 4 || last) begin
      w.data = '0;
      for (int i = 0; i < part_q.size(); i++) w.data[i*8 +: 8] = part_q[i];
      w.lanes = part_q.size();
      w.last  = last;
      exp_q.push_back(w);
      part_q.delete();
    end
  endtask

  // Monitor on the falling edge: handshakes seen here complete at the next rising edge.
  always @(negedge clk) begin
    if (reset) begin
      part_q.delete();
      exp_q.delete();
      hold_prev = 1'b0;
      check_eq("rx_ready_in_reset", 64'(rx_ready), 64'd0);
    end else begin
      check_eq("rx_ready_rule", 64'(rx_ready), 64'(!tx_valid || tx_ready));
      if (hold_prev) begin
        check_eq("stable_valid", 64'(tx_valid), 64'd1);
        check_eq("stable_data", 64'(tx_data), 64'(prev_data));
        check_eq("stable_lanes", 64'(tx_lanes), 64'(prev_lanes));
        check_eq("stable_last", 64'(tx_last), 64'(prev_last));
      end
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("tx_unexpected_word", 64'(exp_q.size()), 64'd1);
        end else begin
          w_got = exp_q.pop_front();
          check_eq("sb_data", 64'(tx_data), 64'(w_got.data));
          check_eq("sb_lanes", 64'(tx_lanes), 64'(w_got.lanes));
          check_eq("sb_last", 64'(tx_last), 64'(w_got.last));
          n_words++;
        end
      end
      if (rx_valid && rx_ready) model_beat(rx_data, rx_last);
      hold_prev  = tx_valid && !tx_ready;
      prev_data  = tx_data;
      prev_lanes = tx_lanes;
      prev_last  = tx_last;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the beat is taken.
  task automatic send(input logic [7:0] d, input bit last);
    int n;
    n = 0;
    rx_valid = 1'b1;
    rx_data  = d;
    rx_last  = last;
    @(negedge clk);
    while (!rx_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) check_eq("rx_accept_timeout", 64'(n), 64'd0);
    stall_cnt += n;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_last  = 1'b0;
  endtask

  task automatic check_word(input string tag, input logic [31:0] d, input int lanes, input bit last);
    check_eq({tag, "_valid"}, 64'(tx_valid), 64'd1);
    check_eq({tag, "_data"}, 64'(tx_data), 64'(d));
    check_eq({tag, "_lanes"}, 64'(tx_lanes), 64'(lanes));
    check_eq({tag, "_last"}, 64'(tx_last), 64'(last));
  endtask

  task automatic idle_cycle();
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  int   start_cyc;
  int   start_words;
  int   sent;
  int   guard;
  logic fired;

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = '0;
    rx_last  = 1'b0;
    tx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_tx_valid", 64'(tx_valid), 64'd0);
    check_eq("reset_tx_data", 64'(tx_data), 64'd0);
    check_eq("reset_tx_lanes", 64'(tx_lanes), 64'd0);
    check_eq("reset_tx_last", 64'(tx_last), 64'd0);
    check_eq("reset_rx_ready", 64'(rx_ready), 64'd0);
    reset    = 1'b0;
    tx_ready = 1'b1;
    @(posedge clk); #1;

    // Full word, single-cycle valid
    send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b0);
    check_word("full", 32'h44332211, 4, 1'b0);
    @(posedge clk); #1;
    check_eq("full_valid_one_cycle", 64'(tx_valid), 64'd0);

    // Short packet, then TLAST on lane 0
    send(8'hAA, 1'b0); send(8'hBB, 1'b1);
    check_word("short", 32'h0000BBAA, 2, 1'b1);
    send(8'h01, 1'b1);
    check_word("lane0_last", 32'h00000001, 1, 1'b1);
    idle_cycle();

    // Backpressure
    tx_ready = 1'b0;
    send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b0);
    check_word("bp", 32'h44332211, 4, 1'b0);
    rx_valid = 1'b1;
    rx_data  = 8'h55;
    rx_last  = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq("bp_rx_ready_low", 64'(rx_ready), 64'd0);
      check_eq("bp_hold_data", 64'(tx_data), 64'h44332211);
      @(posedge clk); #1;
    end
    tx_ready = 1'b1;
    @(negedge clk);
    check_eq("bp_release_ready", 64'(rx_ready), 64'd1);
    @(posedge clk); #1;
    rx_valid = 1'b0;
    check_eq("bp_release_valid", 64'(tx_valid), 64'd0);
    send(8'h66, 1'b0); send(8'h77, 1'b0); send(8'h88, 1'b0);
    check_word("bp_next", 32'h88776655, 4, 1'b0);
    idle_cycle();

    // Streaming: 64 beats back to back
    stall_cnt   = 0;
    start_cyc   = cyc;
    start_words = n_words;
    for (int i = 0; i < 64; i++) send(8'(i), 1'b0);
    check_eq("stream_cycles", 64'(cyc - start_cyc), 64'd64);
    check_eq("stream_stalls", 64'(stall_cnt), 64'd0);
    check_word("stream_last_word", 32'h3F3E3D3C, 4, 1'b0);
    idle_cycle();
    check_eq("stream_word_count", 64'(n_words - start_words), 64'd16);

    // Reset mid-packet
    send(8'h11, 1'b0); send(8'h22, 1'b0);
    reset = 1'b1;
    #1;
    check_eq("midrst_rx_ready", 64'(rx_ready), 64'd0);
    @(posedge clk); #1;
    check_eq("midrst_tx_valid", 64'(tx_valid), 64'd0);
    check_eq("midrst_tx_data", 64'(tx_data), 64'd0);
    check_eq("midrst_tx_lanes", 64'(tx_lanes), 64'd0);
    check_eq("midrst_tx_last", 64'(tx_last), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    send(8'h33, 1'b0); send(8'h44, 1'b0); send(8'h55, 1'b0); send(8'h66, 1'b0);
    check_word("midrst_first", 32'h66554433, 4, 1'b0);
    idle_cycle();

    // Random throttling on both sides
    sent  = 0;
    guard = 0;
    rx_valid = 1'b0;
    while (sent < 10000 && guard < 60000) begin
      if (!rx_valid && $urandom_range(0, 2) != 0) begin
        rx_valid = 1'b1;
        rx_data  = 8'($urandom);
        rx_last  = ($urandom_range(0, 5) == 0);
      end
      tx_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      fired = rx_valid && rx_ready;
      @(posedge clk); #1;
      if (fired) begin
        rx_valid = 1'b0;
        sent++;
      end
      guard++;
    end
    check_eq("random_beats_sent", 64'(sent), 64'd10000);
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("random_drain_pending", 64'(exp_q.size()), 64'd0);
    check_eq("random_drain_valid", 64'(tx_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
